// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, FSM states and lane helpers shared by the data-memory responder
package mem_pkg;
  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} mem_op_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} resp_state_e;
  function automatic logic is_store(input mem_op_e op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] a);
    return (op inside {LH, LHU, SH} && a[0]) || (op inside {LW, SW} && a != 2'd0);
  endfunction
  function automatic logic [3:0] byte_en(input mem_op_e op, input logic [1:0] a);
    return op == SB ? 4'b0001 << a : op == SH ? 4'b0011 << a : op == SW ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised synchronous RAM with byte write enables and a registered read port
module dmem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  // byte-lane writes
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  // read register only updates on a load access, so it holds through the response
  always_ff @(posedge clk)
    if (re) rdata <= mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states and lane shifting
module dmem_responder import mem_pkg::*; #(
  parameter int SIZE        = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SIZE-1:0] req_addr,
  input  logic [2:0]      req_ctrl,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);
  resp_state_e     state, next;
  mem_op_e         ctrl_q;
  logic [SIZE-1:0] addr_q;
  logic [31:0]     wdata_q, word;
  logic [3:0]      cnt;
  logic            err_q, accept, req_err;
  assign req_ready = rst_n && state == S_IDLE;
  assign accept    = req_valid && req_ready;
  assign req_err   = is_misaligned(mem_op_e'(req_ctrl), req_addr[1:0]);
  // state register, wait counter and request latches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ctrl_q  <= LB;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        ctrl_q  <= mem_op_e'(req_ctrl);
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        cnt     <= 4'(WAIT_CYCLES - 1);
      end else if (state == S_WAIT) cnt <= cnt - 4'd1;
    end
  // next-state: misaligned requests skip straight to the response
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   if (accept) next = req_err ? S_RESP : WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd0) next = S_ACCESS;
      S_ACCESS: next = S_RESP;
      S_RESP:   if (rsp_ready) next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end
  dmem_array #(.AW(SIZE - 2)) u_array (
    .clk   (clk),
    .addr  (addr_q[SIZE-1:2]),
    .we    (state == S_ACCESS ? byte_en(ctrl_q, addr_q[1:0]) : 4'b0000),
    .re    (state == S_ACCESS && !is_store(ctrl_q)),
    .wdata (ctrl_q == SB ? {4{wdata_q[7:0]}} : ctrl_q == SH ? {2{wdata_q[15:0]}} : wdata_q),
    .rdata (word)
  );
  assign rsp_valid = state == S_RESP;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid && !err_q && !is_store(ctrl_q) ? word >> {addr_q[1:0], 3'b000} : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with WAIT_CYCLES=1 and WAIT_CYCLES=0 instances
module tb_dmem_responder;
  import mem_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  logic        clk = 0, rst_n = 0, sel = 0;
  logic        req_valid = 0, rsp_ready = 1;
  logic [11:0] req_addr = '0;
  logic [2:0]  req_ctrl = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        rdy0, rdy1, v0, v1, e0, e1;
  logic [31:0] d0, d1;
  logic [31:0] mdl [1024];
  exp_t        q[$];
  int          n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  dmem_responder #(.SIZE(12), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(rdy0),
    .req_addr(req_addr), .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .rsp_valid(v0), .rsp_ready(rsp_ready), .rsp_rdata(d0), .rsp_err(e0)
  );
  dmem_responder #(.SIZE(12), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(rdy1),
    .req_addr(req_addr), .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_ready(rsp_ready), .rsp_rdata(d1), .rsp_err(e1)
  );
  assign req_ready = sel ? rdy1 : rdy0;
  assign rsp_valid = sel ? v1 : v0;
  assign rsp_rdata = sel ? d1 : d0;
  assign rsp_err   = sel ? e1 : e0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model_op(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d);
    exp_t e;
    int   sh;
    sh = 8 * int'(a[1:0]);
    e.err = ((c == 3'd1 || c == 3'd4 || c == 3'd6) && a[0]) || ((c == 3'd2 || c == 3'd7) && a[1:0] != 2'd0);
    e.lat = e.err ? 1 : 2 + (sel ? 0 : 1);
    e.rdata = '0;
    if (!e.err) begin
      if (c == 3'd5) mdl[a[11:2]][sh +: 8] = d[7:0];
      else if (c == 3'd6) mdl[a[11:2]][sh +: 16] = d[15:0];
      else if (c == 3'd7) mdl[a[11:2]] = d;
      else e.rdata = mdl[a[11:2]] >> sh;
    end
    return e;
  endfunction
  task automatic xact(input string tag, input mem_op_e c, input logic [11:0] a, input logic [31:0] d, input int hold = 0);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid = 1; req_ctrl = c; req_addr = a; req_wdata = d; rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    q.push_back(model_op(c, a, d));
    @(negedge clk);
    req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    e = q.pop_front();
    chk({tag, "_rdata"}, rsp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    chk({tag, "_lat"}, n, e.lat);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_ctrl = SW; req_addr = a; req_wdata = '0;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    chk({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst_n = 1; #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    xact("sw10", SW, 12'h010, 32'hDEADBEEF);
    xact("lw10a", LW, 12'h010, 32'h0);
    xact("sb13", SB, 12'h013, 32'h000000AA);
    xact("lw10b", LW, 12'h010, 32'h0);
    xact("lbu13", LBU, 12'h013, 32'h0);
    xact("sh12", SH, 12'h012, 32'h00001234);
    xact("lh12", LH, 12'h012, 32'h0);
    xact("lw10c", LW, 12'h010, 32'h0);
    xact("lb11", LB, 12'h011, 32'h0);
    xact("lhu10", LHU, 12'h010, 32'h0);
    xact("lw11", LW, 12'h011, 32'h0);
    xact("sh13", SH, 12'h013, 32'h0000FFFF);
    xact("lhu11", LHU, 12'h011, 32'h0);
    xact("lw10d", LW, 12'h010, 32'h0);
    xact("swffc", SW, 12'hFFC, 32'hCAFEF00D);
    xact("sbffc", SB, 12'hFFD, 32'h00000077);
    xact("lwffc", LW, 12'hFFC, 32'h0);
    xact("hold", LW, 12'h010, 32'h0, 5);
    xact("lw10e", LW, 12'h010, 32'h0);
    xact("sw20", SW, 12'h020, 32'h11111111);
    @(negedge clk);
    req_valid = 1; req_ctrl = SW; req_addr = 12'h020; req_wdata = 32'h55; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0; rst_n = 0; #1;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1;
    xact("lw20", LW, 12'h020, 32'h0);
    @(negedge clk);
    req_valid = 1; req_ctrl = LW; req_addr = 12'h020; rsp_ready = 0;
    @(negedge clk); req_valid = 0;
    repeat (3) @(negedge clk);
    chk("resp_pre_rst", 32'(rsp_valid), 32'd1);
    rst_n = 0; #1;
    chk("resp_rst_valid", 32'(rsp_valid), 32'd0);
    chk("resp_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst_n = 1; rsp_ready = 1;
    sel = 1;
    xact("w0_sw40", SW, 12'h040, 32'h0BADF00D);
    xact("w0_lw40", LW, 12'h040, 32'h0);
    xact("w0_lh42", LHU, 12'h042, 32'h0);
    xact("w0_lw41", LW, 12'h041, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
